regfile_scoreboard: RTL

- Parametrised successor of the core's `Registers` block: an integer register file with configurable data width and register count (RV32I = 32 or RV32E = 16 entries).
- Adds synchronous reset and hardwired x0.
- Adds an issue/writeback scoreboard that flags source registers with an outstanding write, so the decode stage can stall.
- Sits between decode (read/issue) and writeback (write/retire) in the Grande-Risco-5 pipeline.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_pending_tracker.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and types for the integer register file with scoreboard.
//   - REG_COUNT_RV32I / REG_COUNT_RV32E: the two legal register counts.
//   - DEFAULT_ADDR_WIDTH / reg_addr_t: default-width register address type.
//   - ZERO_REG: architectural x0, hardwired to zero.
//   Width-specific address types are declared locally by the modules that
//   import this package, since a package cannot be parameterised.
package regfile_pkg;

  localparam int REG_COUNT_RV32I    = 32;
  localparam int REG_COUNT_RV32E    = 16;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_pending_tracker.sv
// regfile_pending_tracker
//   One pending bit per architectural register, marking an issued instruction
//   whose writeback has not yet happened.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset (clears all bits)
//     set_en/set_idx: issue of a (validated, non-x0) destination register
//     clr_en/clr_idx: writeback to a (validated, non-x0) register
//     pending       : current pending vector; bit 0 is always 0
//   Priority: on the same register, set beats clear -- the newly issued
//   instruction supersedes the writeback of the older one.
module regfile_pending_tracker #(
  parameter int REG_COUNT = 32,
  parameter int IDX_W     = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [IDX_W-1:0]     set_idx,
  input  logic                 clr_en,
  input  logic [IDX_W-1:0]     clr_idx,
  output logic [REG_COUNT-1:0] pending
);

  logic [REG_COUNT-1:0] pending_q;
  logic [REG_COUNT-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_idx] = 1'b0;
    // Applied after the clear so a same-register collision ends up set.
    if (set_en) pending_d[set_idx] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Integer register file (RV32I: 32 or RV32E: 16 entries) with hardwired x0,
//   synchronous reset and an issue/writeback scoreboard that flags source
//   operands with an outstanding write so decode can stall.
//   Ports:
//     clk, rst_i                     : clock, synchronous active-high reset
//     wr_en_i, RD_ADDR_i, data_i     : writeback port
//     RS1_ADDR_i/RS1_data_o          : combinational read port 1
//     RS2_ADDR_i/RS2_data_o          : combinational read port 2
//     issue_en_i, issue_rd_i         : destination of the issuing instruction
//     RS1_busy_o, RS2_busy_o, stall_o: scoreboard hazard flags
//     illegal_addr_o                 : some presented address >= REG_COUNT
//   Optional feature macro REGFILE_BYPASS_EN: forwards the writeback data to a
//   matching read port in the same cycle and suppresses its busy flag (unless
//   the same register is re-issued in that cycle). Without it, reads show the
//   stored value and busy drops only after the writeback edge.
//   Handshake: there is no valid/ready pair; wr_en_i and issue_en_i are
//   single-cycle strobes that are always accepted on the edge they are high.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] RS1_ADDR_i,
  input  logic [ADDR_WIDTH-1:0] RS2_ADDR_i,
  output logic [DATA_WIDTH-1:0] RS1_data_o,
  output logic [DATA_WIDTH-1:0] RS2_data_o,
  input  logic                  issue_en_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  output logic                  RS1_busy_o,
  output logic                  RS2_busy_o,
  output logic                  stall_o,
  output logic                  illegal_addr_o
);

  localparam int IDX_W = $clog2(REG_COUNT);

  if ((REG_COUNT != REG_COUNT_RV32I) && (REG_COUNT != REG_COUNT_RV32E)) begin : g_bad_count
    $error("regfile_scoreboard: REG_COUNT must be 32 or 16");
  end
  if ((2 ** ADDR_WIDTH) < REG_COUNT) begin : g_bad_width
    $error("regfile_scoreboard: ADDR_WIDTH too small for REG_COUNT");
  end

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(REG_COUNT);
  localparam addr_t               X0        = addr_t'(ZERO_REG);

  function automatic logic in_range(input addr_t a);
    return {1'b0, a} < REG_LIMIT;
  endfunction

  // Usable means: in range and not x0, i.e. a real storage/pending slot.
  function automatic logic usable(input addr_t a);
    return in_range(a) && (a != X0);
  endfunction

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0]  pending;

  logic wr_ok;
  logic issue_ok;
  logic rs1_ok;
  logic rs2_ok;

  assign wr_ok    = wr_en_i && usable(RD_ADDR_i);
  assign issue_ok = issue_en_i && usable(issue_rd_i);
  assign rs1_ok   = usable(RS1_ADDR_i);
  assign rs2_ok   = usable(RS2_ADDR_i);

  // Storage. regs[0] is never written, so it stays at its reset value 0;
  // reads additionally gate x0 to zero.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[RD_ADDR_i[IDX_W-1:0]] <= data_i;
    end
  end

  regfile_pending_tracker #(
    .REG_COUNT (REG_COUNT),
    .IDX_W     (IDX_W)
  ) u_pending (
    .clk     (clk),
    .rst     (rst_i),
    .set_en  (issue_ok),
    .set_idx (issue_rd_i[IDX_W-1:0]),
    .clr_en  (wr_ok),
    .clr_idx (RD_ADDR_i[IDX_W-1:0]),
    .pending (pending)
  );

  logic [DATA_WIDTH-1:0] rs1_stored;
  logic [DATA_WIDTH-1:0] rs2_stored;
  logic                  rs1_pend;
  logic                  rs2_pend;

  assign rs1_stored = rs1_ok ? regs[RS1_ADDR_i[IDX_W-1:0]] : '0;
  assign rs2_stored = rs2_ok ? regs[RS2_ADDR_i[IDX_W-1:0]] : '0;
  assign rs1_pend   = rs1_ok & pending[RS1_ADDR_i[IDX_W-1:0]];
  assign rs2_pend   = rs2_ok & pending[RS2_ADDR_i[IDX_W-1:0]];

`ifdef REGFILE_BYPASS_EN
  // wr_ok already implies the address is a usable slot, so an equal read
  // address is usable too.
  logic byp1;
  logic byp2;
  logic reissue1;
  logic reissue2;

  assign byp1     = wr_ok && (RD_ADDR_i == RS1_ADDR_i);
  assign byp2     = wr_ok && (RD_ADDR_i == RS2_ADDR_i);
  assign reissue1 = issue_ok && (issue_rd_i == RS1_ADDR_i);
  assign reissue2 = issue_ok && (issue_rd_i == RS2_ADDR_i);

  assign RS1_data_o = byp1 ? data_i : rs1_stored;
  assign RS2_data_o = byp2 ? data_i : rs2_stored;
  // A same-cycle re-issue keeps the register busy: the forwarded value
  // belongs to the older instruction.
  assign RS1_busy_o = rs1_pend & ~(byp1 & ~reissue1);
  assign RS2_busy_o = rs2_pend & ~(byp2 & ~reissue2);
`else
  assign RS1_data_o = rs1_stored;
  assign RS2_data_o = rs2_stored;
  assign RS1_busy_o = rs1_pend;
  assign RS2_busy_o = rs2_pend;
`endif

  assign stall_o = RS1_busy_o | RS2_busy_o;

  assign illegal_addr_o = !in_range(RS1_ADDR_i)
                        | !in_range(RS2_ADDR_i)
                        | (wr_en_i && !in_range(RD_ADDR_i))
                        | (issue_en_i && !in_range(issue_rd_i));

endmodule
